// File: rtl/cpu_div_pkg.sv
// Shared types, constants and helpers for the cpu_div_cell iterative divider.
package cpu_div_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int MAX_WIDTH     = 128;

   localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Callers zero-extend into MAX_WIDTH and truncate back; the low bits are the W-bit negate.
   function automatic logic [MAX_WIDTH-1:0] cond_neg(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 neg);
      return neg ? -value : value;
   endfunction

endpackage

// File: rtl/cpu_div_if.sv
// Operand/result bundle between the E stage (master) and the divider (slave).
interface cpu_div_if
   import cpu_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] E_src1;
   logic [WIDTH-1:0] E_src2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_op, E_src1, E_src2,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, E_src1, E_src2,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/cpu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract.
module cpu_div_step
   import cpu_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // The shifted remainder needs one extra bit; the difference always fits in WIDTH.
   assign shifted  = {rem, dvd_bit};
   assign diff     = shifted[WIDTH-1:0] - divisor;
   assign q_bit    = (shifted >= {1'b0, divisor});
   assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];
endmodule

// File: rtl/cpu_div_cell.sv
// Iterative radix-2 restoring divider (signed/unsigned) with a one-cycle done pulse.
// Optional macro CPU_DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module cpu_div_cell
   import cpu_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic     clk,
   input  logic     reset,
   cpu_div_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] rem_reg, dvd_reg, dvs_reg, src1_reg;
   logic [WIDTH-1:0] quot_reg, remd_reg;
   logic             neg_q_reg, neg_r_reg, dvz_reg;
   logic             busy_reg, done_reg, dvz_out_reg;

   logic [WIDTH-1:0] abs_a, abs_b, step_rem;
   logic             step_q, early;

   assign abs_a = WIDTH'(cond_neg(MAX_WIDTH'(bus.E_src1), bus.signed_op & bus.E_src1[WIDTH-1]));
   assign abs_b = WIDTH'(cond_neg(MAX_WIDTH'(bus.E_src2), bus.signed_op & bus.E_src2[WIDTH-1]));

`ifdef CPU_DIV_EARLY_OUT_EN
   assign early = (abs_b != '0) && (abs_a < abs_b);
`else
   assign early = 1'b0;
`endif

   cpu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_reg),
      .dvd_bit  (dvd_reg[WIDTH-1]),
      .divisor  (dvs_reg),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (bus.start) state_next = early ? FIX : ITER;
         ITER:    if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg     <= '0;
         rem_reg     <= '0;
         dvd_reg     <= '0;
         dvs_reg     <= '0;
         src1_reg    <= '0;
         quot_reg    <= '0;
         remd_reg    <= '0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         dvz_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         dvz_out_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: if (bus.start) begin
               neg_q_reg <= bus.signed_op & (bus.E_src1[WIDTH-1] ^ bus.E_src2[WIDTH-1]);
               neg_r_reg <= bus.signed_op & bus.E_src1[WIDTH-1];
               dvs_reg   <= abs_b;
               src1_reg  <= bus.E_src1;
               dvz_reg   <= (bus.E_src2 == '0);
               // Early out parks the whole magnitude in the remainder so FIX yields q=0, r=src1.
               rem_reg   <= early ? abs_a : '0;
               dvd_reg   <= early ? '0 : abs_a;
               cnt_reg   <= '0;
               busy_reg  <= 1'b1;
            end
            ITER: begin
               rem_reg <= step_rem;
               dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            FIX: begin
               quot_reg    <= dvz_reg ? {WIDTH{DIV0_QUOTIENT[0]}}
                                      : WIDTH'(cond_neg(MAX_WIDTH'(dvd_reg), neg_q_reg));
               remd_reg    <= dvz_reg ? src1_reg
                                      : WIDTH'(cond_neg(MAX_WIDTH'(rem_reg), neg_r_reg));
               dvz_out_reg <= dvz_reg;
               done_reg    <= 1'b1;
               busy_reg    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.quotient    = quot_reg;
   assign bus.remainder   = remd_reg;
   assign bus.div_by_zero = dvz_out_reg;
endmodule

// File: tb/tb_cpu_div_cell.sv
// Self-checking bench for cpu_div_cell: directed cases, handshake/reset scenarios, random ops.
module tb_cpu_div_cell;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cpu_div_if #(.WIDTH(W)) bus ();

   cpu_div_cell #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   // Reference: plain integer division rules, plus the divide-by-zero and overflow conventions.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z, output int lat);
      logic [31:0] ma, mb;
      int sa, sb;
      z   = (b == 32'd0);
      ma  = (s && a[31]) ? -a : a;
      mb  = (s && b[31]) ? -b : b;
      lat = W + 1;
`ifdef CPU_DIV_EARLY_OUT_EN
      if (!z && ma < mb) lat = 1;
`endif
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.E_src1    = a;
      bus.E_src2    = b;
      bus.signed_op = s;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      // Operands must not be sampled after the start cycle.
      bus.E_src1 = $urandom;
      bus.E_src2 = $urandom;
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!bus.done && edges < 100);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] q, r;
      logic z;
      int lat, edges;
      model(a, b, s, q, r, z, lat);
      start_op(a, b, s);
      chk(tag, "busy_rise", 64'(bus.busy), 64'(1));
      wait_done(edges);
      chk(tag, "latency", 64'(edges), 64'(lat));
      chk(tag, "quotient", 64'(bus.quotient), 64'(q));
      chk(tag, "remainder", 64'(bus.remainder), 64'(r));
      chk(tag, "dbz", 64'(bus.div_by_zero), 64'(z));
      chk(tag, "busy_fall", 64'(bus.busy), 64'(0));
      $display("op %s: %h / %h signed=%0d -> q=%h r=%h dbz=%0d edges=%0d",
               tag, a, b, s, bus.quotient, bus.remainder, bus.div_by_zero, edges);
      @(posedge clk);
      #1;
      chk(tag, "done_pulse", 64'(bus.done), 64'(0));
      chk(tag, "q_hold", 64'(bus.quotient), 64'(q));
   endtask

   initial begin
      logic [31:0] qa, ra, qb, rb, a, b;
      logic za, zb, s;
      int la, lb, edges, dones, done_edge, mode;

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.E_src1    = '0;
      bus.E_src2    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", "busy", 64'(bus.busy), 64'(0));
      chk("reset", "done", 64'(bus.done), 64'(0));
      chk("reset", "quotient", 64'(bus.quotient), 64'(0));
      chk("reset", "remainder", 64'(bus.remainder), 64'(0));
      chk("reset", "dbz", 64'(bus.div_by_zero), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      run_op("udiv", 32'd100, 32'd7, 1'b0);
      run_op("sneg_dividend", 32'hFFFF_FF9C, 32'd7, 1'b1);
      run_op("sneg_divisor", 32'd100, 32'hFFFF_FFF9, 1'b1);
      run_op("div0", 32'h1234_5678, 32'd0, 1'b0);
      run_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op("small_over_big", 32'd3, 32'd10, 1'b0);

      // Starts pulsed while busy must be dropped.
      model(32'd100, 32'd7, 1'b0, qa, ra, za, la);
      start_op(32'd100, 32'd7, 1'b0);
      dones = 0;
      done_edge = 0;
      for (int e = 1; e <= 60; e++) begin
         @(negedge clk);
         bus.start = (e == 5 || e == 10);
         if (e == 5 || e == 10) begin
            bus.E_src1 = 32'd1000;
            bus.E_src2 = 32'd3;
         end
         @(posedge clk);
         #1;
         if (bus.done) begin
            dones++;
            done_edge = e;
         end
      end
      bus.start = 1'b0;
      chk("busy_start", "done_count", 64'(dones), 64'(1));
      chk("busy_start", "done_edge", 64'(done_edge), 64'(la));
      chk("busy_start", "quotient", 64'(bus.quotient), 64'(qa));
      $display("op busy_start: dones=%0d done_edge=%0d q=%h", dones, done_edge, bus.quotient);

      // Start held high across FIX: ignored there, accepted on the cycle after done.
      model(32'd1000, 32'd9, 1'b0, qa, ra, za, la);
      model(32'hFFFF_FFCE, 32'd4, 1'b1, qb, rb, zb, lb);
      start_op(32'd1000, 32'd9, 1'b0);
      for (int e = 1; e <= 33; e++) begin
         @(negedge clk);
         if (e >= 31) begin
            bus.start     = 1'b1;
            bus.E_src1    = 32'hFFFF_FFCE;
            bus.E_src2    = 32'd4;
            bus.signed_op = 1'b1;
         end
         @(posedge clk);
         #1;
         if (e == 33) begin
            chk("held_start", "a_done", 64'(bus.done), 64'(1));
            chk("held_start", "a_quotient", 64'(bus.quotient), 64'(qa));
            chk("held_start", "a_remainder", 64'(bus.remainder), 64'(ra));
            chk("held_start", "fix_ignores_start", 64'(bus.busy), 64'(0));
         end
      end
      @(posedge clk);
      #1;
      chk("held_start", "b_accept", 64'(bus.busy), 64'(1));
      chk("held_start", "b_no_done", 64'(bus.done), 64'(0));
      bus.start  = 1'b0;
      bus.E_src1 = $urandom;
      wait_done(edges);
      chk("held_start", "b_latency", 64'(edges), 64'(lb));
      chk("held_start", "b_quotient", 64'(bus.quotient), 64'(qb));
      chk("held_start", "b_remainder", 64'(bus.remainder), 64'(rb));
      $display("op held_start: q=%h r=%h edges=%0d", bus.quotient, bus.remainder, edges);

      // Reset mid-operation aborts without a done pulse.
      start_op(32'd12345, 32'd17, 1'b0);
      repeat (14) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_reset", "busy", 64'(bus.busy), 64'(0));
      chk("mid_reset", "done", 64'(bus.done), 64'(0));
      chk("mid_reset", "quotient", 64'(bus.quotient), 64'(0));
      chk("mid_reset", "remainder", 64'(bus.remainder), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      chk("mid_reset", "no_done", 64'(dones), 64'(0));
      $display("op mid_reset: dones_after_reset=%0d", dones);
      run_op("after_reset", 32'd12345, 32'd17, 1'b0);

      for (int i = 0; i < 24; i++) begin
         mode = $urandom_range(0, 4);
         a = $urandom;
         s = 1'($urandom_range(0, 1));
         case (mode)
            0:       b = $urandom;
            1:       b = 32'($urandom_range(1, 255));
            2:       b = -32'($urandom_range(1, 100));
            3:       begin b = $urandom; a = 32'($urandom_range(0, 1000)); end
            default: b = 32'd0;
         endcase
         run_op($sformatf("rand%0d", i), a, b, s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_div_cell.md
Name: cpu_div_cell

Overview:
Iterative radix-2 restoring divider; the division counterpart to the pipelined multiply cell in the Nios II execute path.
Accepts a dividend/divisor pair from the E stage, computes quotient and remainder over multiple cycles, and signals completion with a one-cycle done pulse.
Supports signed and unsigned operation. Holds results stable until the next accepted start.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while busy=0
signed_op  input  1  1 = two's-complement divide, 0 = unsigned
E_src1  input  WIDTH  dividend
E_src2  input  WIDTH  divisor
busy  output  1  high from the edge accepting start through the edge raising done
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered with done; divisor was 0

Behaviour:
- Reset (synchronous, active-high): state=IDLE. busy=0, done=0, div_by_zero=0. quotient=0, remainder=0. Counter cleared.
- Reset mid-operation aborts the operation. No done is produced.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE: on start=1, capture the following:
  - neg_q = signed_op & (src1[W-1]^src2[W-1])
  - neg_r = signed_op & src1[W-1]
  - magnitudes |src1| and |src2| (unsigned if signed_op=0)
  - partial remainder = 0; counter = 0; busy<=1; go to ITER.
- ITER: one restoring step per cycle.
  - Shift {rem, dvd} left by 1.
  - If rem >= |divisor|, set rem -= |divisor| and set the quotient LSB to 1.
  - After WIDTH steps (counter == WIDTH-1), go to FIX.
- FIX: apply sign correction: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r. Register outputs, pulse done=1, busy<=0, go to IDLE.
- Latency: done is visible after edge WIDTH+1 counted from the start-accepting edge (edge 0); 33 edges for WIDTH=32. busy falls on that same edge.
- start while busy=1 is ignored, with no queuing. start in the same cycle as done (state FIX) is ignored; a new start is accepted on the following cycle.
- Divide by zero: no short path; full latency.
  - quotient = all ones; remainder = E_src1 as given; div_by_zero = 1.
- Signed overflow (-2^(W-1) / -1): quotient = 0x80000000, remainder = 0, no flag. The W-bit wrap-around of the negation handles this naturally.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Outputs hold their last values while IDLE. Operand inputs are not sampled after the start cycle.

Optional Feature:
CPU_DIV_EARLY_OUT_EN
- Defined: in IDLE, if the divisor is nonzero and |dividend| < |divisor| (unsigned magnitude compare), go directly to FIX.
  - quotient = 0; remainder = E_src1 as given.
  - done is visible after edge 1.
- Not defined: every operation takes the full WIDTH+1 edges. The comparator is not instantiated.

Decomposition:
- Package cpu_div_pkg:
  - state enum (IDLE, ITER, FIX)
  - DIV0_QUOTIENT all-ones constant
  - default WIDTH constant
  - helper function for conditional two's-complement negate
- One sub-module, cpu_div_step: combinational single restoring iteration.
  - Inputs: rem, dvd bit, divisor.
  - Outputs: next rem, quotient bit.

Test Plan:
- Unsigned 100/7, signed_op=0 -> done after 33 edges, quotient=14, remainder=2, div_by_zero=0.
- Signed -100/7 (0xFFFFFF9C / 7) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100/-7 -> quotient=-14, remainder=2.
- 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. 0x80000000/0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
- Handshake:
  - start pulsed at edges 5 and 10 during a busy op -> exactly one done; the second start is ignored.
  - start held high across FIX -> the next op begins the cycle after done.
- reset=1 at edge 15 of an op -> busy=0, quotient=remainder=0, no done pulse. The next start completes normally.
- With CPU_DIV_EARLY_OUT_EN: 3/10 unsigned -> done after edge 1, quotient=0, remainder=3. Without the macro: the same op takes 33 edges, same result.
